// File: rtl/rst_seq.sv
// -----------------------------------------------------------------------------
// rst_seq: reset conditioner for downstream I2C logic.
//
// Synchronises an asynchronous active-low reset request and rejects short
// glitches on it. A qualified request, or a software reset pulse, puts the
// downstream logic into reset. Once the request is released, the reset output
// is held for a further STRETCH_CYCLES cycles. Rejected glitches are counted.
//
// Ports
//   Clk        in   single clock, rising edge
//   Rst        in   asynchronous active-high reset
//   RstReq_n   in   active-low reset request, asynchronous to Clk
//   SwRst      in   software reset pulse, synchronous, active-high
//   RstOut     out  conditioned reset, active-high, driven by a flop
//   RstOut_n   out  inverse of RstOut
//   Ready      out  high only while the sequencer is in RUN
//   GlitchCnt  out  saturating count of rejected request pulses
// -----------------------------------------------------------------------------
module rst_seq #(
   parameter int unsigned SYNC_STAGES    = 2,
   parameter int unsigned FILTER_CYCLES  = 4,
   parameter int unsigned STRETCH_CYCLES = 16
) (
   input  logic       Clk,
   input  logic       Rst,
   input  logic       RstReq_n,
   input  logic       SwRst,
   output logic       RstOut,
   output logic       RstOut_n,
   output logic       Ready,
   output logic [7:0] GlitchCnt
);

   typedef enum logic [1:0] {
      StHold    = 2'd0,
      StStretch = 2'd1,
      StRun     = 2'd2,
      StQualify = 2'd3
   } state_e;

   localparam logic [7:0] StretchLast = 8'(STRETCH_CYCLES - 1);
   localparam logic [7:0] FilterLast  = 8'(FILTER_CYCLES - 1);

   logic [SYNC_STAGES-1:0] r_sync;
   logic                   w_req_sync;
   state_e                 r_state;
   state_e                 w_state_d;
   logic [7:0]             r_scnt;
   logic [7:0]             w_scnt_d;
   logic [7:0]             r_fcnt;
   logic [7:0]             w_fcnt_d;
   logic [7:0]             r_glitch;
   logic [7:0]             w_glitch_d;
   logic                   r_rst_out;
   logic                   r_ready;

   // Synchroniser resets to 0 so the request reads as active until proven idle.
   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         r_sync <= '0;
      end else begin
         r_sync <= {r_sync[SYNC_STAGES-2:0], RstReq_n};
      end
   end

   assign w_req_sync = r_sync[SYNC_STAGES-1];

   // Next-state logic; SwRst is tested first everywhere so it dominates ReqSync.
   always_comb begin
      w_state_d  = r_state;
      w_scnt_d   = r_scnt;
      w_fcnt_d   = r_fcnt;
      w_glitch_d = r_glitch;
      unique case (r_state)
         StHold: begin
            if (w_req_sync && !SwRst) begin
               w_state_d = StStretch;
               w_scnt_d  = '0;
            end
         end
         StStretch: begin
            if (!w_req_sync || SwRst) begin
               w_state_d = StHold;
               w_scnt_d  = '0;
            end else if (r_scnt == StretchLast) begin
               w_state_d = StRun;
            end else begin
               w_scnt_d = r_scnt + 8'd1;
            end
         end
         StRun: begin
            if (SwRst) begin
               w_state_d = StHold;
            end else if (!w_req_sync) begin
               w_state_d = StQualify;
               w_fcnt_d  = 8'd1;
            end
         end
         StQualify: begin
            if (SwRst) begin
               w_state_d = StHold;
            end else if (w_req_sync) begin
               // Request vanished before qualifying: count it as a glitch.
               w_state_d = StRun;
               if (r_glitch != 8'hFF) begin
                  w_glitch_d = r_glitch + 8'd1;
               end
            end else if (r_fcnt == FilterLast) begin
               w_state_d = StHold;
            end else begin
               w_fcnt_d = r_fcnt + 8'd1;
            end
         end
         default: begin
            w_state_d = StHold;
         end
      endcase
   end

   // Output flops are loaded from the next state so they track r_state exactly
   // while staying glitch-free.
   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         r_state   <= StHold;
         r_scnt    <= '0;
         r_fcnt    <= '0;
         r_glitch  <= '0;
         r_rst_out <= 1'b1;
         r_ready   <= 1'b0;
      end else begin
         r_state   <= w_state_d;
         r_scnt    <= w_scnt_d;
         r_fcnt    <= w_fcnt_d;
         r_glitch  <= w_glitch_d;
         r_rst_out <= (w_state_d == StHold) || (w_state_d == StStretch);
         r_ready   <= (w_state_d == StRun);
      end
   end

   assign RstOut    = r_rst_out;
   assign RstOut_n  = ~r_rst_out;
   assign Ready     = r_ready;
   assign GlitchCnt = r_glitch;

endmodule

// File: doc/rst_seq.md
RST_SEQ -- requirements
Module: rst_seq

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2: number of synchronizer flops on RstReq_n (legal range 2..4).
REQ-002 SHALL have parameter FILTER_CYCLES, default 4: number of consecutive low synchronized samples needed to accept a reset request (legal range 2..255).
REQ-003 SHALL have parameter STRETCH_CYCLES, default 16: number of cycles RstOut stays high after the request is released (legal range 1..255).
REQ-004 SHALL have port Clk, input, 1 bit: the single clock; all flops SHALL use its rising edge.
REQ-005 SHALL have port Rst, input, 1 bit: reset, asynchronous and active-high.
REQ-006 SHALL have port RstReq_n, input, 1 bit: reset request from the system reset generator, active-low and asynchronous to Clk.
REQ-007 SHALL have port SwRst, input, 1 bit: software reset request, synchronous to Clk, active-high, single-cycle pulse.
REQ-008 SHALL have port RstOut, output, 1 bit: conditioned reset to downstream I2C logic, active-high.
REQ-009 SHALL have port RstOut_n, output, 1 bit: always the inverse of RstOut.
REQ-010 SHALL have port Ready, output, 1 bit: high only in state RUN.
REQ-011 SHALL have port GlitchCnt, output, 8 bits: saturating count of rejected (filtered) request pulses.

Function
REQ-012 SHALL pass RstReq_n through a chain of SYNC_STAGES flops; the last stage is ReqSync, and all stages SHALL reset to 0 (request active).
REQ-013 SHALL implement the FSM states HOLD, STRETCH, RUN and QUALIFY, with a state register, an 8-bit stretch counter scnt and an 8-bit filter counter fcnt.
REQ-014 HOLD: if ReqSync=1 and SwRst=0, SHALL go to STRETCH with scnt=0; otherwise SHALL stay in HOLD.
REQ-015 STRETCH: if ReqSync=0 or SwRst=1, SHALL go to HOLD with scnt=0; else if scnt=STRETCH_CYCLES-1, SHALL go to RUN; else SHALL increment scnt.
REQ-016 RUN: if SwRst=1, SHALL go to HOLD directly without filtering; else if ReqSync=0, SHALL go to QUALIFY with fcnt=1.
REQ-017 QUALIFY: if SwRst=1, SHALL go to HOLD; else if ReqSync=1, SHALL return to RUN and increment GlitchCnt; else if fcnt=FILTER_CYCLES-1, SHALL go to HOLD; else SHALL increment fcnt.
REQ-018 SHALL saturate GlitchCnt at 255 with no wrap; only Rst clears it.
REQ-019 SHALL drive RstOut from a dedicated flop, 1 exactly when the registered state is HOLD or STRETCH, with no combinational glitches.
REQ-020 SHALL keep RstOut=0 and Ready=0 in QUALIFY: downstream sees no reset until the request is qualified.
REQ-021 SHALL have SwRst dominate ReqSync when both are active in the same cycle.
REQ-022 SHALL give a latency from an RstReq_n edge to ReqSync of SYNC_STAGES edges, ±1 edge of metastability uncertainty.

Reset
REQ-023 When Rst=1, SHALL asynchronously force: state=HOLD, RstOut=1, RstOut_n=0, Ready=0, GlitchCnt=0, scnt=0, fcnt=0, synchronizer=0.
REQ-024 SHALL apply Rst independently of Clk and give it priority over all other inputs; Rst asserted in any state, including mid-STRETCH or mid-QUALIFY, SHALL abort immediately with no residual count.
REQ-025 SHALL sample Rst deassertion synchronously; the first rising edge after Rst falls is edge 1.

Verification
REQ-026 Hold RstReq_n=1, release Rst -> ReqSync=1 after edge 2, STRETCH at edge 3, and RUN at edge 19 (RstOut=0, RstOut_n=1, Ready=1).
REQ-027 In RUN, drive RstReq_n low for 2 cycles -> passes through QUALIFY, returns to RUN, RstOut stays 0 throughout, GlitchCnt=1.
REQ-028 In RUN, drive RstReq_n low for 6 cycles -> HOLD reached after 4 consecutive low ReqSync samples, RstOut=1, Ready=0; after release, RUN returns 16 cycles after STRETCH entry.
REQ-029 In STRETCH with scnt=10, pulse RstReq_n low long enough to be synchronized -> HOLD, scnt=0, and a full 16-cycle stretch restarts on release.
REQ-030 Pulse SwRst in RUN together with RstReq_n=1 -> HOLD on the next edge with no filter delay; in QUALIFY, SwRst SHALL also go straight to HOLD with GlitchCnt unchanged.
REQ-031 Inject 300 rejected glitches, then assert Rst mid-QUALIFY -> GlitchCnt=255 before Rst, then immediately RstOut=1 and GlitchCnt=0.
